// File: rtl/i2s_dac_tx.sv
// ----------------------------------------------------------------------------
// i2s_dac_tx
//
// Parallel-to-serial I2S transmitter for a WM8731 DAC running in slave mode.
// One stereo pair per frame is accepted over a valid/ready handshake into a
// holding register. At the start of every frame the holding register is moved
// into the frame shift register and shifted out MSB-first with the standard
// I2S one-bit delay after the LRCK edge. BCLK and DACLRCK are generated here
// from the master clock.
//
// Parameters
//   DATA_W     sample width in bits (two's complement, sent unchanged)
//   SLOT_W     BCLK periods per channel slot (>= DATA_W); trailing pad bits are 0
//   BCLK_HALF  master clock cycles per BCLK half-period
//
// Ports
//   sample_clock  in   master clock, all logic on the rising edge
//   reset         in   synchronous, active-high
//   in_valid      in   in_left/in_right carry a valid pair
//   in_ready      out  holding register empty; pair transfers on valid & ready
//   in_left       in   left sample
//   in_right      in   right sample
//   aud_bclk      out  I2S bit clock
//   aud_daclrck   out  0 = left slot, 1 = right slot
//   aud_dacdat    out  serial data, changes while BCLK is low
//   frame_start   out  1-cycle pulse when a frame is loaded
//   underrun      out  1-cycle pulse when a frame is loaded with holding empty
// ----------------------------------------------------------------------------
module i2s_dac_tx #(
    parameter int unsigned DATA_W    = 16,
    parameter int unsigned SLOT_W    = 16,
    parameter int unsigned BCLK_HALF = 6
) (
    input  logic              sample_clock,
    input  logic              reset,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] in_left,
    input  logic [DATA_W-1:0] in_right,
    output logic              aud_bclk,
    output logic              aud_daclrck,
    output logic              aud_dacdat,
    output logic              frame_start,
    output logic              underrun
);

    // Master clock cycles per BCLK period, and BCLK periods per frame.
    localparam int unsigned P    = 2 * BCLK_HALF;
    localparam int unsigned NPER = 2 * SLOT_W;
    localparam int unsigned PH_W = $clog2(P);
    localparam int unsigned K_W  = $clog2(NPER);

    // The frame counter is kept as (period, phase) so no divider is needed;
    // fc == 0 exactly when both are zero.
    logic [PH_W-1:0]   r_phase;
    logic [PH_W-1:0]   w_phase_d;
    logic [K_W-1:0]    r_period;
    logic [K_W-1:0]    w_period_d;

    logic              w_phase_zero;
    logic              w_phase_last;
    logic              w_period_last;
    logic              w_load;
    logic              w_accept;

    // Holding register (second half of the double buffer).
    logic              r_hold_full;
    logic              w_hold_full_d;
    logic [DATA_W-1:0] r_hold_l;
    logic [DATA_W-1:0] r_hold_r;
    logic [DATA_W-1:0] w_hold_l_d;
    logic [DATA_W-1:0] w_hold_r_d;

    // Frame word, MSB is the first bit on the wire.
    logic [SLOT_W-1:0] w_slot_l;
    logic [SLOT_W-1:0] w_slot_r;
    logic [NPER-1:0]   w_frame;
    logic [NPER-1:0]   r_shift;
    logic [NPER-1:0]   w_shift_d;

    // Registered outputs.
    logic              r_in_ready;
    logic              r_bclk;
    logic              r_lrck;
    logic              r_dacdat;
    logic              r_frame_start;
    logic              r_underrun;

    // ------------------------------------------------------------------------
    // Frame timing
    // ------------------------------------------------------------------------
    always_comb begin
        w_phase_zero  = (r_phase == '0);
        w_phase_last  = (r_phase == PH_W'(P - 1));
        w_period_last = (r_period == K_W'(NPER - 1));
        w_load        = w_phase_zero && (r_period == '0);

        w_phase_d  = w_phase_last ? '0 : r_phase + PH_W'(1);
        w_period_d = r_period;
        if (w_phase_last) begin
            w_period_d = w_period_last ? '0 : r_period + K_W'(1);
        end
    end

    // ------------------------------------------------------------------------
    // Input handshake and holding register
    // ------------------------------------------------------------------------
    assign w_accept = in_valid && r_in_ready;

    always_comb begin
        w_hold_full_d = r_hold_full;
        w_hold_l_d    = r_hold_l;
        w_hold_r_d    = r_hold_r;
        // A load drains the holding register; an accept in the same cycle
        // refills it for the following frame, so the accept must win.
        if (w_load) begin
            w_hold_full_d = 1'b0;
        end
        if (w_accept) begin
            w_hold_full_d = 1'b1;
            w_hold_l_d    = in_left;
            w_hold_r_d    = in_right;
        end
    end

    // ------------------------------------------------------------------------
    // Frame word assembly and shift register
    // ------------------------------------------------------------------------
    always_comb begin
        w_slot_l = '0;
        w_slot_r = '0;
        w_slot_l[SLOT_W-1 -: DATA_W] = r_hold_l;
        w_slot_r[SLOT_W-1 -: DATA_W] = r_hold_r;
        w_frame  = {w_slot_l, w_slot_r};
    end

    // The top bit of r_shift is the next bit to go out. At the start of a
    // frame it still holds the last bit of the previous frame, which gives the
    // one-bit I2S delay for free: output the top bit, then load.
    always_comb begin
        w_shift_d = r_shift;
        if (w_load) begin
            w_shift_d = r_hold_full ? w_frame : '0;
        end else if (w_phase_zero) begin
            w_shift_d = r_shift << 1;
        end
    end

    // ------------------------------------------------------------------------
    // State registers
    // ------------------------------------------------------------------------
    always_ff @(posedge sample_clock) begin
        if (reset) begin
            r_phase     <= '0;
            r_period    <= '0;
            r_hold_full <= 1'b0;
            r_hold_l    <= '0;
            r_hold_r    <= '0;
            r_shift     <= '0;
        end else begin
            r_phase     <= w_phase_d;
            r_period    <= w_period_d;
            r_hold_full <= w_hold_full_d;
            r_hold_l    <= w_hold_l_d;
            r_hold_r    <= w_hold_r_d;
            r_shift     <= w_shift_d;
        end
    end

    // ------------------------------------------------------------------------
    // Output registers: one cycle behind the frame counter
    // ------------------------------------------------------------------------
    always_ff @(posedge sample_clock) begin
        if (reset) begin
            r_in_ready    <= 1'b0;
            r_bclk        <= 1'b0;
            r_lrck        <= 1'b0;
            r_dacdat      <= 1'b0;
            r_frame_start <= 1'b0;
            r_underrun    <= 1'b0;
        end else begin
            r_in_ready    <= !w_hold_full_d;
            r_bclk        <= (r_phase >= PH_W'(BCLK_HALF));
            r_lrck        <= (r_period >= K_W'(SLOT_W));
            // Data only moves in the BCLK-low half, so it is stable at the rise.
            if (w_phase_zero) begin
                r_dacdat <= r_shift[NPER-1];
            end
            r_frame_start <= w_load;
            r_underrun    <= w_load && !r_hold_full;
        end
    end

    assign in_ready    = r_in_ready;
    assign aud_bclk    = r_bclk;
    assign aud_daclrck = r_lrck;
    assign aud_dacdat  = r_dacdat;
    assign frame_start = r_frame_start;
    assign underrun    = r_underrun;

endmodule

// File: tb/tb_i2s_dac_tx.sv
// ----------------------------------------------------------------------------
// tb_i2s_dac_tx
//
// Directed bench for i2s_dac_tx. A default instance (SLOT_W=16) is checked
// every cycle against the expected BCLK/LRCK waveform, frame_start/underrun
// pulses and the serial bit at each BCLK rise, using a per-frame table of
// expected frame words. A second instance with SLOT_W=32 checks slot padding.
// Time index t counts clock edges since reset release; edge 0 loads frame 0.
// ----------------------------------------------------------------------------
module tb_i2s_dac_tx;

    localparam int FRAME = 384;

    logic        clk;
    logic        reset;
    logic        in_valid;
    logic        in_ready;
    logic [15:0] in_left;
    logic [15:0] in_right;
    logic        aud_bclk;
    logic        aud_daclrck;
    logic        aud_dacdat;
    logic        frame_start;
    logic        underrun;

    logic        in_valid2;
    logic        in_ready2;
    logic [15:0] in_left2;
    logic [15:0] in_right2;
    logic        aud_bclk2;
    logic        aud_daclrck2;
    logic        aud_dacdat2;
    logic        frame_start2;
    logic        underrun2;

    i2s_dac_tx #(
        .DATA_W    (16),
        .SLOT_W    (16),
        .BCLK_HALF (6)
    ) u_dut (
        .sample_clock (clk),
        .reset        (reset),
        .in_valid     (in_valid),
        .in_ready     (in_ready),
        .in_left      (in_left),
        .in_right     (in_right),
        .aud_bclk     (aud_bclk),
        .aud_daclrck  (aud_daclrck),
        .aud_dacdat   (aud_dacdat),
        .frame_start  (frame_start),
        .underrun     (underrun)
    );

    i2s_dac_tx #(
        .DATA_W    (16),
        .SLOT_W    (32),
        .BCLK_HALF (6)
    ) u_dut32 (
        .sample_clock (clk),
        .reset        (reset),
        .in_valid     (in_valid2),
        .in_ready     (in_ready2),
        .in_left      (in_left2),
        .in_right     (in_right2),
        .aud_bclk     (aud_bclk2),
        .aud_daclrck  (aud_daclrck2),
        .aud_dacdat   (aud_dacdat2),
        .frame_start  (frame_start2),
        .underrun     (underrun2)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int          n_chk;
    int          n_pass;
    int          t;
    bit          mon;
    logic [31:0] fw [0:31];   // expected frame word per frame index
    logic        fu [0:31];   // expected underrun per frame index

    typedef struct {
        bit          push;
        logic [15:0] l;
        logic [15:0] r;
        logic [31:0] exp_word;   // word sent in the following frame
        logic        exp_under;  // underrun at the following frame start
    } vec_t;

    vec_t vecs [0:6];

    function automatic void chk(input string name, input logic act, input logic exp);
        n_chk++;
        if (act === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s at t=%0d: got %b, expected %b", name, t, act, exp);
        end
    endfunction

    // Advance one edge, then check the default instance against the frame table.
    task automatic tick();
        int   fc;
        int   k;
        int   ph;
        int   f;
        logic e;
        @(posedge clk);
        #1;
        t++;
        if (mon) begin
            fc = t % FRAME;
            k  = fc / 12;
            ph = fc % 12;
            f  = t / FRAME;
            chk("bclk", aud_bclk, logic'(ph >= 6));
            chk("lrck", aud_daclrck, logic'(k >= 16));
            chk("frame_start", frame_start, logic'(fc == 0));
            chk("underrun", underrun, logic'(fc == 0) & fu[f]);
            if (ph == 6) begin
                if (k == 0) begin
                    e = (f == 0) ? 1'b0 : fw[f-1][0];
                end else begin
                    e = fw[f][32-k];
                end
                chk("dacdat", aud_dacdat, e);
            end
        end
    endtask

    task automatic run_to(input int target);
        while (t < target) tick();
    endtask

    task automatic check_idle();
        chk("rst_ready", in_ready, 1'b0);
        chk("rst_bclk", aud_bclk, 1'b0);
        chk("rst_lrck", aud_daclrck, 1'b0);
        chk("rst_dat", aud_dacdat, 1'b0);
        chk("rst_fs", frame_start, 1'b0);
        chk("rst_under", underrun, 1'b0);
        chk("rst32_ready", in_ready2, 1'b0);
        chk("rst32_bclk", aud_bclk2, 1'b0);
        chk("rst32_under", underrun2, 1'b0);
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        int          n;
        logic [63:0] w64;

        n_chk     = 0;
        n_pass    = 0;
        t         = 0;
        mon       = 1'b0;
        reset     = 1'b1;
        in_valid  = 1'b0;
        in_left   = '0;
        in_right  = '0;
        in_valid2 = 1'b0;
        in_left2  = '0;
        in_right2 = '0;
        for (int i = 0; i < 32; i++) begin
            fw[i] = '0;
            fu[i] = 1'b1;
        end

        vecs[0] = '{1'b1, 16'hA5F0, 16'h0F5A, 32'hA5F0_0F5A, 1'b0};
        vecs[1] = '{1'b0, 16'h0000, 16'h0000, 32'h0000_0000, 1'b1};
        vecs[2] = '{1'b1, 16'h8000, 16'h7FFF, 32'h8000_7FFF, 1'b0};
        vecs[3] = '{1'b1, 16'hFFFF, 16'h0001, 32'hFFFF_0001, 1'b0};
        vecs[4] = '{1'b1, 16'h0000, 16'h0000, 32'h0000_0000, 1'b0};
        vecs[5] = '{1'b1, 16'h1234, 16'hFEDC, 32'h1234_FEDC, 1'b0};
        vecs[6] = '{1'b0, 16'h0000, 16'h0000, 32'h0000_0000, 1'b1};

        // Reset held for five edges: everything idle.
        repeat (5) tick();
        check_idle();

        // Release; frame 0 is a zero frame with underrun.
        fw[0] = '0;
        fu[0] = 1'b1;
        reset = 1'b0;
        t     = -1;
        mon   = 1'b1;

        // Table: one push (or none) per frame at fc=100.
        for (int i = 0; i < 7; i++) begin
            run_to(i * FRAME + 100);
            chk("tbl_ready_idle", in_ready, 1'b1);
            fw[i+1] = vecs[i].exp_word;
            fu[i+1] = vecs[i].exp_under;
            if (vecs[i].push) begin
                in_valid = 1'b1;
                in_left  = vecs[i].l;
                in_right = vecs[i].r;
                tick();
                chk("tbl_ready_after_accept", in_ready, 1'b0);
                // Valid while not ready must be ignored.
                in_left  = 16'hDEAD;
                in_right = 16'hBEEF;
                repeat (10) begin
                    tick();
                    chk("tbl_ready_full", in_ready, 1'b0);
                end
                in_valid = 1'b0;
            end
        end

        // Valid exactly on the fc==0 cycle with holding empty.
        run_to(7 * FRAME + 383);
        chk("edge_ready", in_ready, 1'b1);
        fw[8] = '0;
        fu[8] = 1'b1;
        fw[9] = 32'hC3C3_3C3C;
        fu[9] = 1'b0;
        in_valid = 1'b1;
        in_left  = 16'hC3C3;
        in_right = 16'h3C3C;
        tick();
        in_valid = 1'b0;
        chk("edge_ready_after", in_ready, 1'b0);

        // Ramp with valid held high: one accept per frame, right after each load.
        run_to(9 * FRAME + 50);
        chk("ramp_ready_start", in_ready, 1'b1);
        fw[10] = 32'h0001_FFFF;
        fw[11] = 32'h0002_FFFE;
        fw[12] = 32'h0003_FFFD;
        fw[13] = 32'h0004_FFFC;
        fu[10] = 1'b0;
        fu[11] = 1'b0;
        fu[12] = 1'b0;
        fu[13] = 1'b0;
        fw[14] = '0;
        fu[14] = 1'b1;
        fw[15] = '0;
        fu[15] = 1'b1;
        n        = 1;
        in_valid = 1'b1;
        in_left  = 16'(n);
        in_right = 16'(-n);
        while (n <= 4) begin
            tick();
            if (t == 9 * FRAME + 51 || (t % FRAME == 1 && t > 9 * FRAME + 51)) begin
                chk("ramp_ready_accepted", in_ready, 1'b0);
                n++;
                in_left  = 16'(n);
                in_right = 16'(-n);
                if (n > 4) in_valid = 1'b0;
            end else begin
                chk("ramp_ready", in_ready, logic'(t % FRAME == 0));
            end
        end

        // Fill holding, then reset mid-frame at fc=200: the pair is lost.
        run_to(15 * FRAME + 150);
        chk("pre_rst_ready", in_ready, 1'b1);
        in_valid = 1'b1;
        in_left  = 16'hC0DE;
        in_right = 16'hBEEF;
        tick();
        in_valid = 1'b0;
        chk("pre_rst_full", in_ready, 1'b0);
        run_to(15 * FRAME + 199);
        reset = 1'b1;
        mon   = 1'b0;
        tick();
        check_idle();
        repeat (2) tick();

        for (int i = 0; i < 8; i++) begin
            fw[i] = '0;
            fu[i] = 1'b1;
        end
        reset = 1'b0;
        t     = -1;
        mon   = 1'b1;

        run_to(0);
        chk("post_rst_ready", in_ready, 1'b1);
        chk("s32_fs0", frame_start2, 1'b1);
        chk("s32_under0", underrun2, 1'b1);

        // SLOT_W=32 instance: pad bits after each 16-bit sample must be zero.
        run_to(100);
        chk("s32_ready", in_ready2, 1'b1);
        in_valid2 = 1'b1;
        in_left2  = 16'hABCD;
        in_right2 = 16'h1357;
        tick();
        in_valid2 = 1'b0;
        chk("s32_ready_after", in_ready2, 1'b0);

        run_to(768);
        chk("s32_fs1", frame_start2, 1'b1);
        chk("s32_under1", underrun2, 1'b0);
        w64 = 64'hABCD_0000_1357_0000;
        for (int k = 1; k <= 64; k++) begin
            run_to(768 + 12 * k + 6);
            chk("s32_dat", aud_dacdat2, w64[64-k]);
            chk("s32_lrck", aud_daclrck2, logic'(k >= 32 && k < 64));
            chk("s32_bclk", aud_bclk2, 1'b1);
        end

        run_to(1560);
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
